// File: rtl/store_buffer_pkg.sv
// Store-size encodings shared by the store buffer, load extender and control unit.
// The width of each size code is fixed by the MEM-stage control field.
package store_buffer_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } st_size_e;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/store_lane_packer.sv
// Narrows 32-bit register data into big-endian byte lanes with matching byte enables.
// Also reports whether the store is misaligned for its size.
module store_lane_packer
    import store_buffer_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  st_size_e    size_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic        misaligned_o
);

    // Offset 0 maps to be[3]; the reserved size code is rejected as misaligned.
    always_comb begin
        wdata_o      = '0;
        be_o         = '0;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                wdata_o = {4{data_i[7:0]}};
                be_o    = 4'b1000 >> addr_lo_i;
            end
            SZ_HALF: begin
                wdata_o      = {2{data_i[15:0]}};
                be_o         = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                misaligned_o = addr_lo_i[0];
            end
            SZ_WORD: begin
                wdata_o      = data_i;
                be_o         = 4'b1111;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and the data-memory write port: narrows stores, queues
// them in a small FIFO, drains over valid/ready and flags loads hitting a pending word.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              st_misalign,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic              empty
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-3:0] addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        be_q   [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              misalign_q;

    logic [31:0] packWdata;
    logic [3:0]  packBe;
    logic        packMis;
    logic        enq, deq, accept;
    logic        unusedLdLo;

    store_lane_packer u_packer (
        .addr_lo_i    (st_addr[1:0]),
        .size_i       (st_size_e'(st_size)),
        .data_i       (st_data),
        .wdata_o      (packWdata),
        .be_o         (packBe),
        .misaligned_o (packMis)
    );

    assign st_ready    = (count_q != FULL_CNT);
    assign mem_valid   = (count_q != '0);
    assign empty       = (count_q == '0);
    assign st_misalign = misalign_q;
    assign mem_addr    = {addr_q[head_q], 2'b00};
    assign mem_wdata   = data_q[head_q];
    assign mem_be      = be_q[head_q];
    assign unusedLdLo  = ^ld_addr[1:0];

    // A misaligned store still completes its handshake but never occupies an entry.
    assign accept = st_valid && st_ready;
    assign enq    = accept && !packMis;
    assign deq    = mem_valid && mem_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (deq) begin
            head_d          = head_q + PTR_W'(1);
            valid_d[head_q] = 1'b0;
        end
        if (enq) begin
            tail_d          = tail_q + PTR_W'(1);
            valid_d[tail_q] = 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            misalign_q <= accept && packMis;
            if (enq) begin
                addr_q[tail_q] <= st_addr[ADDR_W-1:2];
                data_q[tail_q] <= packWdata;
                be_q[tail_q]   <= packBe;
            end
        end
    end

    // Only registered entries are compared, so a store arriving this cycle cannot hit.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == ld_addr[ADDR_W-1:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

endmodule
